// File: rtl/dense_seq_ctrl.sv
// Fully-connected layer sequencer: streams weight rows from an external ROM into
// N_OUT MAC lanes, then adds bias, rescales, saturates and hands the vector downstream.
module dense_seq_ctrl #(
  parameter int unsigned N_IN  = 32,
  parameter int unsigned N_OUT = 5,
  parameter int unsigned WIDTH = 22,
  parameter int unsigned NFRAC = 11,
  parameter int unsigned ACC_W = 2*WIDTH + $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*WIDTH-1:0]    in_data,
  output logic                     rom_en,
  output logic [$clog2(N_IN)-1:0]  rom_addr,
  input  logic [N_OUT*WIDTH-1:0]   rom_row,
  input  logic [N_OUT*WIDTH-1:0]   bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(N_IN);
  localparam int unsigned PW = 2*WIDTH;
  localparam int unsigned SW = ACC_W + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, OUT} state_t;

  state_t                    state, state_d;
  logic [AW-1:0]             cnt, cnt_d;
  logic                      accept;

  logic [N_IN*WIDTH-1:0]     x_q;
  logic                      en_q;
  logic [AW-1:0]             addr_q;
  logic signed [ACC_W-1:0]   acc [N_OUT];
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [ACC_W-1:0]   prod_ext [N_OUT];
  logic signed [SW-1:0]      scaled [N_OUT];
  logic [N_OUT*WIDTH-1:0]    result_c;

  // State register and row counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; RUN issues one row per cycle with the counter as address
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == AW'(N_IN-1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt + AW'(1);
        end
      end
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      rom_en    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      rom_en    <= (state_d == RUN);
      out_valid <= (state_d == OUT);
    end
  end

  assign rom_addr = cnt;

  // Full-precision products; rom_row belongs to the address issued one cycle earlier
  assign x_sel = $signed(x_q[32'(addr_q)*WIDTH +: WIDTH]);

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      prod_ext[j] = ACC_W'(PW'(x_sel) * PW'($signed(rom_row[j*WIDTH +: WIDTH])));
    end
  end

  // Bias add in accumulator scale, floor rescale, saturate to the word range
  always_comb begin
    result_c = '0;
    for (int j = 0; j < N_OUT; j++) begin
      scaled[j] = (SW'(acc[j]) + (SW'($signed(bias_in[j*WIDTH +: WIDTH])) <<< NFRAC)) >>> NFRAC;
      if (scaled[j] > SAT_MAX) begin
        result_c[j*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
      end else if (scaled[j] < SAT_MIN) begin
        result_c[j*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
      end else begin
        result_c[j*WIDTH +: WIDTH] = scaled[j][WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      out_data <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      en_q   <= rom_en;
      addr_q <= rom_addr;
      if (accept) x_q <= in_data;
      for (int j = 0; j < N_OUT; j++) begin
        if (accept)    acc[j] <= '0;
        else if (en_q) acc[j] <= acc[j] + prod_ext[j];
      end
      if (state == FINISH) out_data <= result_c;
    end
  end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Self-checking bench for dense_seq_ctrl: behavioural weight ROM, scoreboard of
// reference-model results pushed on accept and popped when out_valid appears.
`timescale 1ns/1ps
module tb_dense_seq_ctrl;

  localparam int unsigned N_IN   = 32;
  localparam int unsigned N_OUT  = 5;
  localparam int unsigned W      = 22;
  localparam int unsigned NFRAC  = 11;
  localparam int unsigned AW     = $clog2(N_IN);
  localparam int          LAT    = N_IN + 3;
  localparam int          PERIOD = N_IN + 4;
  localparam int          BUDGET = 400;
  localparam longint      SMAX   = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint      SMIN   = -(64'sd1 <<< (W-1));

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N_IN*W-1:0]    in_data = '0;
  logic                 rom_en;
  logic [AW-1:0]        rom_addr;
  logic [N_OUT*W-1:0]   rom_row = '0;
  logic [N_OUT*W-1:0]   bias_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [N_OUT*W-1:0]   out_data;
  logic                 busy;

  logic [W-1:0]         w_mem [N_IN][N_OUT];
  logic [N_OUT*W-1:0]   exp_q [$];
  int                   addr_log [$];
  int                   addr_cyc [$];
  int                   cyc = 0;
  int                   accept_cyc = 0;
  int                   accepts = 0;
  int                   errors = 0;
  int                   checks = 0;

  dense_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_row   (rom_row),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM: one-cycle read latency, junk on the bus when not enabled
  always @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++)
      rom_row[j*W +: W] <= rom_en ? w_mem[rom_addr][j] : W'($urandom);
  end

  function automatic logic [N_OUT*W-1:0] model(input logic [N_IN*W-1:0] x);
    logic [N_OUT*W-1:0] res = '0;
    logic [W-1:0] xv, bv;
    longint acc, s, r;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        xv = x[i*W +: W];
        acc += longint'($signed(xv)) * longint'($signed(w_mem[i][j]));
      end
      bv = bias_in[j*W +: W];
      s = acc + (longint'($signed(bv)) <<< NFRAC);
      r = s >>> NFRAC;
      if (r > SMAX) r = SMAX;
      else if (r < SMIN) r = SMIN;
      res[j*W +: W] = W'(r);
    end
    return res;
  endfunction

  // Accept and ROM-read monitor
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(in_data));
      accept_cyc <= cyc;
      accepts    <= accepts + 1;
      addr_log.delete();
      addr_cyc.delete();
    end
    if (rst_n && rom_en) begin
      addr_log.push_back(int'(rom_addr));
      addr_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] rnd_small();
    return W'(int'($urandom_range(8191)) - 4096);
  endfunction

  task automatic set_w_all(input logic [W-1:0] v);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) w_mem[i][j] = v;
  endtask

  task automatic set_w_rand();
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) w_mem[i][j] = rnd_small();
  endtask

  task automatic set_bias_all(input logic [W-1:0] v);
    for (int j = 0; j < N_OUT; j++) bias_in[j*W +: W] = v;
  endtask

  function automatic logic [N_IN*W-1:0] rand_vec();
    logic [N_IN*W-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*W +: W] = rnd_small();
    return v;
  endfunction

  task automatic send_vector(input string name, input logic [N_IN*W-1:0] v, output int acc_c);
    bit ok = 0;
    acc_c = -1;
    @(posedge clk); #1;
    in_data  = v;
    in_valid = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; acc_c = cyc; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) in_data[i*W +: W] = W'($urandom);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s accept: in_ready never seen in %0d cycles", name, BUDGET); end
  endtask

  task automatic get_output(input string name, output logic [N_OUT*W-1:0] got, output int lat);
    bit seen = 0;
    logic [N_OUT*W-1:0] want;
    got = 'x;
    lat = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s: out_valid not seen within %0d cycles", name, BUDGET);
    end else if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s: output %h with no expected entry", name, out_data);
    end else begin
      got  = out_data;
      lat  = cyc - accept_cyc;
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL %s: out_data=%h expected %h", name, got, want);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en: got %b want 0", rom_en); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_unity();
    logic [N_OUT*W-1:0] got;
    logic [N_OUT*W-1:0] want = {N_OUT{22'h008000}};
    int lat, a;
    bit seq_ok;
    set_w_all(22'h000400);
    set_bias_all('0);
    send_vector("unity", {N_IN{22'h000800}}, a);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL unity_busy: busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    get_output("unity", got, lat);
    checks++; if (got !== want) begin errors++; $display("FAIL unity_value: got %h want %h", got, want); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL unity_latency: got %0d want %0d", lat, LAT); end
    seq_ok = (addr_log.size() == N_IN);
    if (seq_ok)
      for (int i = 0; i < N_IN; i++)
        if (addr_log[i] != i || addr_cyc[i] != accept_cyc + 1 + i) seq_ok = 0;
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL addr_seq: %0d reads logged, want %0d consecutive 0..%0d", addr_log.size(), N_IN, N_IN-1); end
  endtask

  task automatic test_bias_floor();
    logic [N_OUT*W-1:0] got;
    logic [N_IN*W-1:0] x = '0;
    int lat, a;
    set_w_rand();
    for (int j = 0; j < N_OUT; j++) w_mem[0][j] = 22'h000001;
    set_bias_all(22'h000080);
    x[0 +: W] = 22'h3FFFFF;
    send_vector("bias_floor", x, a);
    get_output("bias_floor", got, lat);
    checks++;
    if (got !== {N_OUT{22'h00007F}}) begin errors++; $display("FAIL bias_floor_value: got %h want lanes 00007f", got); end
  endtask

  task automatic test_saturation();
    logic [N_OUT*W-1:0] got;
    int lat, a;
    set_bias_all('0);
    set_w_all(22'h000800);
    send_vector("sat_pos", {N_IN{22'h0FFFFF}}, a);
    get_output("sat_pos", got, lat);
    checks++;
    if (got !== {N_OUT{22'h1FFFFF}}) begin errors++; $display("FAIL sat_pos_value: got %h want lanes 1fffff", got); end
    set_w_all(22'h3FF800);
    send_vector("sat_neg", {N_IN{22'h0FFFFF}}, a);
    get_output("sat_neg", got, lat);
    checks++;
    if (got !== {N_OUT{22'h200000}}) begin errors++; $display("FAIL sat_neg_value: got %h want lanes 200000", got); end
  endtask

  task automatic test_back_to_back();
    int acc_c [3];
    set_w_rand();
    for (int j = 0; j < N_OUT; j++) bias_in[j*W +: W] = rnd_small();
    fork
      begin
        for (int n = 0; n < 3; n++) send_vector("b2b", rand_vec(), acc_c[n]);
      end
      begin
        logic [N_OUT*W-1:0] g;
        int l;
        for (int n = 0; n < 3; n++) get_output("b2b", g, l);
      end
    join
    for (int n = 1; n < 3; n++) begin
      checks++;
      if (acc_c[n] - acc_c[n-1] !== PERIOD) begin
        errors++; $display("FAIL b2b_period: got %0d want %0d", acc_c[n] - acc_c[n-1], PERIOD);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N_OUT*W-1:0] got, snap;
    int lat, a, acc_before, rel, acc2;
    bit stable_ok = 1, seen = 0;
    set_w_rand();
    for (int j = 0; j < N_OUT; j++) bias_in[j*W +: W] = rnd_small();
    @(posedge clk); #1 out_ready = 1'b0;
    send_vector("bp_v1", rand_vec(), a);
    get_output("bp_v1", got, lat);
    snap = out_data;
    acc_before = accepts;
    @(posedge clk); #1;
    in_data  = rand_vec();
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) stable_ok = 0;
    end
    checks++;
    if (!stable_ok) begin errors++; $display("FAIL bp_hold: out_valid=%b out_data=%h in_ready=%b want 1/%h/0", out_valid, out_data, in_ready, snap); end
    checks++;
    if (accepts !== acc_before) begin errors++; $display("FAIL bp_no_accept: accepts=%0d want %0d", accepts, acc_before); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    rel = cyc;
    acc2 = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (in_ready) begin seen = 1; acc2 = cyc; break; end
    end
    checks++;
    if (!seen || acc2 !== rel + 1) begin errors++; $display("FAIL bp_accept_cycle: got %0d want %0d", acc2, rel + 1); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== snap) begin
      errors++; $display("FAIL bp_after_handshake: out_valid=%b out_data=%h want 0/%h", out_valid, out_data, snap);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    get_output("bp_v2", got, lat);
  endtask

  task automatic test_reset_mid_run();
    logic [N_OUT*W-1:0] got;
    int lat, a, pulses = 0;
    bit found = 0;
    set_w_rand();
    send_vector("mid_rst", rand_vec(), a);
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (rom_en && rom_addr == AW'(10)) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_rst_addr10: rom_addr 10 not seen"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || rom_en !== 1'b0 || rom_addr !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_rst_values: in_ready=%b rom_en=%b rom_addr=%0d busy=%b out_valid=%b out_data=%h want 1/0/0/0/0/0",
               in_ready, rom_en, rom_addr, busy, out_valid, out_data);
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_rst_no_pulse: %0d out_valid cycles want 0", pulses); end
    send_vector("post_rst", rand_vec(), a);
    get_output("post_rst", got, lat);
  endtask

  initial begin
    set_w_all('0);
    test_reset();
    test_unity();
    test_bias_floor();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_seq_ctrl.md
Name: dense_seq_ctrl

Overview:
- Sequencer for one fully-connected layer (default 32 inputs x 5 outputs, 22-bit signed fixed point, 11 fractional bits).
- Accepts one input vector and walks the external weight ROM one input row per cycle, feeding N_OUT parallel MAC lanes.
- Adds per-output bias, then rescales and saturates the result.
- Presents the output vector on a valid/ready port to the next layer stage.

Parameters:
- N_IN, 32, number of layer inputs (ROM rows).
- N_OUT, 5, number of layer outputs (MAC lanes, ROM row width in words).
- WIDTH, 22, data/weight/bias word width, two's complement.
- NFRAC, 11, fractional bits of every word.
- ACC_W, 2*WIDTH+$clog2(N_IN), accumulator width per lane.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N_IN*WIDTH  input vector, element i at bits [i*WIDTH +: WIDTH].
- rom_en  out  1  weight ROM read enable.
- rom_addr  out  $clog2(N_IN)  weight row index (input index).
- rom_row  in  N_OUT*WIDTH  weight row, lane j at [j*WIDTH +: WIDTH]; valid exactly 1 cycle after rom_en.
- bias_in  in  N_OUT*WIDTH  per-lane bias, static during operation.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  N_OUT*WIDTH  result vector, same packing as rom_row.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, rom_en=0, rom_addr=0, busy=0, accumulators=0, counter=0.
- States: IDLE, RUN, DRAIN, FINISH, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, clear accumulators, cnt=0, go to RUN.
- RUN:
  - rom_en=1, rom_addr=cnt, cnt++.
  - After issuing addr N_IN-1, go to DRAIN.
  - Exactly N_IN cycles, addresses 0..N_IN-1 in order, no gaps.
- Accumulate pipeline:
  - A 1-cycle delayed copy of rom_en/rom_addr qualifies rom_row.
  - When qualified: acc[j] += sx(x[addr]) * sx(w[j]).
  - Full 2*WIDTH product, sign-extended to ACC_W; no truncation inside the accumulation.
- DRAIN: one cycle, rom_en=0, consumes the last row, then go to FINISH.
- FINISH: one cycle.
  - s = acc[j] + (sx(bias[j]) << NFRAC).
  - r = s >>> NFRAC (arithmetic shift, floor rounding).
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the result into out_data, go to OUT.
- OUT:
  - out_valid=1; out_data held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
- Latency and throughput:
  - Accept at edge T → out_valid high from cycle T+N_IN+3 (35 for defaults).
  - Minimum vector-to-vector period is N_IN+4 cycles.
- in_ready=0 in every state except IDLE. in_valid asserted while busy is ignored and not lost: the upstream must hold it.
- out_data keeps its last value after the handshake until the next FINISH.
- Reset mid-operation (any state): immediate return to reset values, partial sums discarded, no out_valid pulse.
- bias_in and in_data changing during RUN have no effect on the current vector: in_data is latched, and bias is sampled only in FINISH.

Test Plan:
- Unity check: all inputs 0x000800 (1.0), all weights 0x000400 (0.5), bias 0 → every lane out_data=0x008000 (16.0); out_valid first high exactly 35 cycles after accept.
- Address sequence: monitor rom_en/rom_addr → 32 consecutive cycles, addresses 0..31, rom_en low otherwise; one read per vector.
- Bias and floor: x0=0x3FFFFF (−1 LSB), w[0][j]=0x000001, other inputs 0, bias=0x000080 (0.0625) → lane out = 0x00007F (−1 LSB floor plus 128 LSB).
- Saturation: all inputs 0x0FFFFF, all weights 0x000800 → positive lanes 0x1FFFFF. With weights 0x3FF800 (−1.0) → 0x200000.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0, a second in_valid is not accepted. Release → vector 2 accepted in the next IDLE cycle and its result is correct.
- Reset mid-RUN: drop rst_n at rom_addr=10 → outputs return to reset values asynchronously. The next vector after release produces a correct, uncorrupted result.
